// File: rtl/matrixmult_feeder.sv
// Upstream sequencer for the matrixmult FSL coprocessor: buffers one DIM x DIM
// matrix plus one pixel vector and replays them as the interleaved M[i][j], P[j] stream.
module matrixmult_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int DIM        = 4
) (
    input  logic                  FSL_Clk,
    input  logic                  FSL_Rst,
    output logic                  FSL_S_Read,
    input  logic [DATA_WIDTH-1:0] FSL_S_Data,
    input  logic                  FSL_S_Control,
    input  logic                  FSL_S_Exists,
    output logic                  FSL_M_Write,
    output logic [DATA_WIDTH-1:0] FSL_M_Data,
    output logic                  FSL_M_Control,
    input  logic                  FSL_M_Full,
    output logic                  mat_loaded,
    output logic                  err_drop
);

    localparam int MAT_WORDS = DIM * DIM;
    localparam int IW        = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int MW        = (MAT_WORDS > 1) ? $clog2(MAT_WORDS) : 1;
    localparam int EW        = 2 * IW + 1;
    localparam logic [MW-1:0] MAT_LAST = MW'(MAT_WORDS - 1);
    localparam logic [IW-1:0] DIM_LAST = IW'(DIM - 1);

    typedef enum logic [1:0] {IDLE, LOAD_MAT, LOAD_PIX, EMIT} state_t;

    state_t state, state_next;

    logic [DATA_WIDTH-1:0] mat_buf [MAT_WORDS];
    logic [DATA_WIDTH-1:0] pix_buf [DIM];

    logic [MW-1:0] mat_idx;
    logic [IW-1:0] pix_idx;
    logic [EW-1:0] emit_idx;
    logic [EW-1:0] emit_step;
    logic [IW-1:0] emit_i;
    logic [IW-1:0] emit_j;
    logic          emit_sel;
    logic          emit_last;
    logic [MW-1:0] emit_addr;
    logic          rd_fire;
    logic          wr_fire;
    logic          is_ctrl;

    // emit_idx is packed as {i, j, sel}; sel selects the pixel half of each pair
    assign emit_i    = emit_idx[EW-1 -: IW];
    assign emit_j    = emit_idx[IW:1];
    assign emit_sel  = emit_idx[0];
    assign emit_last = (emit_i == DIM_LAST) && (emit_j == DIM_LAST) && emit_sel;
    assign emit_addr = MW'(32'(emit_i) * DIM + 32'(emit_j));
    assign is_ctrl   = FSL_S_Control;
    assign rd_fire   = FSL_S_Read;
    assign wr_fire   = FSL_M_Write;

    always_comb begin
        emit_step = emit_idx;
        if (!emit_sel) begin
            emit_step[0] = 1'b1;
        end else if (emit_j != DIM_LAST) begin
            emit_step = {emit_i, emit_j + IW'(1), 1'b0};
        end else begin
            emit_step = {emit_i + IW'(1), {IW{1'b0}}, 1'b0};
        end
    end

    always_ff @(posedge FSL_Clk or posedge FSL_Rst) begin
        if (FSL_Rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (rd_fire && is_ctrl) begin
                    state_next = LOAD_MAT;
                end
            end
            LOAD_MAT: begin
                if (rd_fire && !is_ctrl && (mat_idx == MAT_LAST)) begin
                    state_next = LOAD_PIX;
                end
            end
            LOAD_PIX: begin
                if (rd_fire) begin
                    if (is_ctrl) begin
                        state_next = LOAD_MAT;
                    end else if (pix_idx == DIM_LAST) begin
                        state_next = EMIT;
                    end
                end
            end
            EMIT: begin
                if (wr_fire && emit_last) begin
                    state_next = LOAD_PIX;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        FSL_S_Read    = FSL_S_Exists && (state != EMIT);
        FSL_M_Write   = (state == EMIT) && !FSL_M_Full;
        FSL_M_Control = (state == EMIT) && emit_last;
        FSL_M_Data    = emit_sel ? pix_buf[emit_j] : mat_buf[emit_addr];
    end

    // A ctrl word anywhere outside EMIT restarts the matrix load from M[0]
    always_ff @(posedge FSL_Clk or posedge FSL_Rst) begin
        if (FSL_Rst) begin
            mat_idx    <= '0;
            pix_idx    <= '0;
            emit_idx   <= '0;
            mat_loaded <= 1'b0;
            err_drop   <= 1'b0;
        end else begin
            err_drop <= (state == IDLE) && rd_fire && !is_ctrl;
            case (state)
                IDLE: begin
                    if (rd_fire && is_ctrl) begin
                        mat_idx <= MW'(1);
                    end
                end
                LOAD_MAT: begin
                    if (rd_fire) begin
                        if (is_ctrl) begin
                            mat_idx <= MW'(1);
                        end else if (mat_idx == MAT_LAST) begin
                            mat_idx    <= '0;
                            pix_idx    <= '0;
                            mat_loaded <= 1'b1;
                        end else begin
                            mat_idx <= mat_idx + MW'(1);
                        end
                    end
                end
                LOAD_PIX: begin
                    if (rd_fire) begin
                        if (is_ctrl) begin
                            mat_loaded <= 1'b0;
                            mat_idx    <= MW'(1);
                            pix_idx    <= '0;
                        end else if (pix_idx == DIM_LAST) begin
                            pix_idx  <= '0;
                            emit_idx <= '0;
                        end else begin
                            pix_idx <= pix_idx + IW'(1);
                        end
                    end
                end
                EMIT: begin
                    if (wr_fire) begin
                        if (emit_last) begin
                            emit_idx <= '0;
                            pix_idx  <= '0;
                        end else begin
                            emit_idx <= emit_step;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge FSL_Clk) begin
        if (rd_fire) begin
            if ((state != EMIT) && is_ctrl) begin
                mat_buf[0] <= FSL_S_Data;
            end else if (state == LOAD_MAT) begin
                mat_buf[mat_idx] <= FSL_S_Data;
            end else if (state == LOAD_PIX) begin
                pix_buf[pix_idx] <= FSL_S_Data;
            end
        end
    end

endmodule

// File: tb/tb_matrixmult_feeder.sv
// Self-checking bench for matrixmult_feeder: directed spec scenarios plus random
// matrices/pixels with random back-pressure, checked against a queue-based model.
module tb_matrixmult_feeder;

    localparam int DW  = 32;
    localparam int DIM = 4;
    localparam int NW  = 2 * DIM * DIM;

    logic          FSL_Clk = 1'b0;
    logic          FSL_Rst;
    logic          FSL_S_Read;
    logic [DW-1:0] FSL_S_Data;
    logic          FSL_S_Control;
    logic          FSL_S_Exists;
    logic          FSL_M_Write;
    logic [DW-1:0] FSL_M_Data;
    logic          FSL_M_Control;
    logic          FSL_M_Full;
    logic          mat_loaded;
    logic          err_drop;

    int tests_run    = 0;
    int tests_failed = 0;
    int err_pulses   = 0;

    logic [32:0] act_q [$];
    logic [32:0] exp_q [$];
    logic [31:0] mat [DIM*DIM];
    logic [31:0] pix [DIM];

    matrixmult_feeder #(.DATA_WIDTH(DW), .DIM(DIM)) dut (
        .FSL_Clk       (FSL_Clk),
        .FSL_Rst       (FSL_Rst),
        .FSL_S_Read    (FSL_S_Read),
        .FSL_S_Data    (FSL_S_Data),
        .FSL_S_Control (FSL_S_Control),
        .FSL_S_Exists  (FSL_S_Exists),
        .FSL_M_Write   (FSL_M_Write),
        .FSL_M_Data    (FSL_M_Data),
        .FSL_M_Control (FSL_M_Control),
        .FSL_M_Full    (FSL_M_Full),
        .mat_loaded    (mat_loaded),
        .err_drop      (err_drop)
    );

    always #5 FSL_Clk = ~FSL_Clk;

    // Output words are collected mid-cycle, away from the edge the drivers move on
    always @(negedge FSL_Clk) begin
        if (!FSL_Rst && FSL_M_Write) act_q.push_back({FSL_M_Control, FSL_M_Data});
        if (!FSL_Rst && err_drop) err_pulses++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, observed still running, expected finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one word and holds it until the DUT pops it; returns 1ns after the pop edge
    task automatic applyStimulus(input logic [31:0] d, input logic c);
        int budget = 0;
        FSL_S_Data    = d;
        FSL_S_Control = c;
        FSL_S_Exists  = 1'b1;
        @(negedge FSL_Clk);
        while (!FSL_S_Read && budget < 200) begin
            @(negedge FSL_Clk);
            budget++;
        end
        checkOutput("s_read", 64'(FSL_S_Read), 64'(1));
        @(posedge FSL_Clk);
        #1;
    endtask

    task automatic stopInput();
        FSL_S_Exists = 1'b0;
    endtask

    task automatic loadMatrix();
        for (int k = 0; k < DIM*DIM; k++) applyStimulus(mat[k], (k == 0));
        stopInput();
    endtask

    task automatic sendPixel();
        for (int k = 0; k < DIM; k++) applyStimulus(pix[k], 1'b0);
        stopInput();
    endtask

    // Reference stream: for each row i and column j, the matrix element then the pixel element
    task automatic buildExpected();
        exp_q.delete();
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                exp_q.push_back({1'b0, mat[i*DIM + j]});
                exp_q.push_back({(i == DIM-1) && (j == DIM-1), pix[j]});
            end
        end
    endtask

    task automatic randomMatrix();
        for (int k = 0; k < DIM*DIM; k++) mat[k] = $urandom;
    endtask

    task automatic randomPixel();
        for (int k = 0; k < DIM; k++) pix[k] = $urandom;
    endtask

    task automatic drainAndCompare(input string tag, input bit stall);
        int budget = 0;
        while (act_q.size() < NW && budget < 1000) begin
            if (stall) FSL_M_Full = ($urandom_range(0, 2) == 0);
            @(posedge FSL_Clk);
            #1;
            budget++;
        end
        FSL_M_Full = 1'b0;
        repeat (4) begin
            @(posedge FSL_Clk);
            #1;
        end
        checkOutput({tag, " count"}, 64'(act_q.size()), 64'(NW));
        for (int k = 0; k < NW && k < act_q.size(); k++)
            checkOutput($sformatf("%s word%0d", tag, k), 64'(act_q[k]), 64'(exp_q[k]));
    endtask

    initial begin
        FSL_Rst       = 1'b1;
        FSL_S_Data    = '0;
        FSL_S_Control = 1'b0;
        FSL_S_Exists  = 1'b0;
        FSL_M_Full    = 1'b0;

        // Reset state
        repeat (3) @(posedge FSL_Clk);
        #1;
        FSL_Rst = 1'b0;
        @(negedge FSL_Clk);
        checkOutput("rst mat_loaded", 64'(mat_loaded), 64'(0));
        checkOutput("rst err_drop", 64'(err_drop), 64'(0));
        checkOutput("rst s_read", 64'(FSL_S_Read), 64'(0));
        checkOutput("rst m_write", 64'(FSL_M_Write), 64'(0));
        checkOutput("rst m_control", 64'(FSL_M_Control), 64'(0));
        @(posedge FSL_Clk);
        #1;

        // Pixel word with no matrix: consumed, one err_drop pulse, nothing written
        applyStimulus(32'h12345678, 1'b0);
        stopInput();
        checkOutput("t4 err_drop high", 64'(err_drop), 64'(1));
        @(posedge FSL_Clk);
        #1;
        checkOutput("t4 err_drop low", 64'(err_drop), 64'(0));
        repeat (3) @(posedge FSL_Clk);
        #1;
        checkOutput("t4 pulses", 64'(err_pulses), 64'(1));
        checkOutput("t4 writes", 64'(act_q.size()), 64'(0));
        checkOutput("t4 mat_loaded", 64'(mat_loaded), 64'(0));

        // Directed matrix and pixel
        mat = '{32'h4124CCCD, 32'h40C80000, 32'h40A9999A, 32'h3C4CCCCD,
                32'h40600000, 32'h40980000, 32'h4111999A, 32'h43164CCD,
                32'hBF07AE14, 32'h4141999A, 32'hC1691EB8, 32'h4040A3D7,
                32'h3C4CCCCD, 32'h40A9999A, 32'h40C80000, 32'h4124CCCD};
        pix = '{32'hBF07AE14, 32'h4141999A, 32'hC1691EB8, 32'h4040A3D7};
        buildExpected();
        loadMatrix();
        checkOutput("t1 mat_loaded", 64'(mat_loaded), 64'(1));
        sendPixel();
        checkOutput("t1 first write", 64'(FSL_M_Write), 64'(1));
        checkOutput("t1 first data", 64'(FSL_M_Data), 64'(32'h4124CCCD));
        drainAndCompare("t1", 1'b0);
        checkOutput("t1 word1", 64'(act_q[1]), 64'({1'b0, 32'hBF07AE14}));
        checkOutput("t1 word8", 64'(act_q[8]), 64'({1'b0, 32'h40600000}));
        checkOutput("t1 word31", 64'(act_q[31]), 64'({1'b1, 32'h4040A3D7}));
        checkOutput("t1 idle write", 64'(FSL_M_Write), 64'(0));
        act_q.delete();

        // Second pixel reuses the held matrix
        randomPixel();
        buildExpected();
        sendPixel();
        drainAndCompare("t3", 1'b0);
        act_q.delete();

        // Same directed stimulus with a 3-cycle back-pressure window at write 5
        pix = '{32'hBF07AE14, 32'h4141999A, 32'hC1691EB8, 32'h4040A3D7};
        buildExpected();
        loadMatrix();
        sendPixel();
        repeat (4) begin
            @(posedge FSL_Clk);
            #1;
        end
        FSL_M_Full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge FSL_Clk);
            checkOutput($sformatf("t2 stall write c%0d", c), 64'(FSL_M_Write), 64'(0));
            checkOutput($sformatf("t2 stall data c%0d", c), 64'(FSL_M_Data), 64'(32'h40A9999A));
            @(posedge FSL_Clk);
            #1;
        end
        FSL_M_Full = 1'b0;
        drainAndCompare("t2", 1'b0);
        act_q.delete();

        // Partial pixel abandoned by a new matrix
        applyStimulus($urandom, 1'b0);
        applyStimulus($urandom, 1'b0);
        randomMatrix();
        applyStimulus(mat[0], 1'b1);
        checkOutput("t5 mat_loaded drop", 64'(mat_loaded), 64'(0));
        for (int k = 1; k < DIM*DIM; k++) applyStimulus(mat[k], 1'b0);
        stopInput();
        checkOutput("t5 mat_loaded", 64'(mat_loaded), 64'(1));
        randomPixel();
        buildExpected();
        sendPixel();
        drainAndCompare("t5", 1'b0);
        act_q.delete();

        // Random matrices and pixels under random back-pressure
        for (int r = 0; r < 3; r++) begin
            randomMatrix();
            loadMatrix();
            for (int p = 0; p < 2; p++) begin
                randomPixel();
                buildExpected();
                sendPixel();
                drainAndCompare($sformatf("rnd%0d_%0d", r, p), 1'b1);
                act_q.delete();
            end
        end

        // Reset during write 10 aborts the group
        randomPixel();
        buildExpected();
        sendPixel();
        repeat (9) begin
            @(posedge FSL_Clk);
            #1;
        end
        FSL_Rst = 1'b1;
        #1;
        checkOutput("t6 m_write", 64'(FSL_M_Write), 64'(0));
        checkOutput("t6 mat_loaded", 64'(mat_loaded), 64'(0));
        checkOutput("t6 m_control", 64'(FSL_M_Control), 64'(0));
        @(posedge FSL_Clk);
        #1;
        FSL_Rst = 1'b0;
        repeat (6) begin
            @(posedge FSL_Clk);
            #1;
        end
        checkOutput("t6 count", 64'(act_q.size()), 64'(9));
        for (int k = 0; k < 9 && k < act_q.size(); k++)
            checkOutput($sformatf("t6 word%0d", k), 64'(act_q[k]), 64'(exp_q[k]));
        act_q.delete();
        applyStimulus($urandom, 1'b0);
        stopInput();
        checkOutput("t6 err_drop", 64'(err_drop), 64'(1));
        repeat (4) begin
            @(posedge FSL_Clk);
            #1;
        end
        checkOutput("t6 no writes", 64'(act_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
